// File: rtl/tag_ctrl_pkg.sv
// rtl/tag_ctrl_pkg.sv - shared geometry, entry layout and FSM encoding for the L1D tag controller
package tag_ctrl_pkg;
  localparam int NUM_WAY     = 8;
  localparam int SET_BITS    = 7;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = 32 - SET_BITS - OFFSET_BITS;
  localparam int WAY_BITS    = $clog2(NUM_WAY);
  localparam int VALID_BIT   = 31;
  localparam int DIRTY_BIT   = 30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/tag_victim_sel.sv
// rtl/tag_victim_sel.sv - victim way choice: lowest invalid way, else round-robin pointer
// or tree pseudo-LRU walk when TAG_CTRL_PLRU_EN is defined
module tag_victim_sel
  import tag_ctrl_pkg::*;
(
  input  logic [NUM_WAY-1:0]  valid_vec,
`ifdef TAG_CTRL_PLRU_EN
  input  logic [NUM_WAY-2:0]  plru_bits,
`else
  input  logic [WAY_BITS-1:0] rr_ptr,
`endif
  output logic [WAY_BITS-1:0] victim_way
);
  logic [WAY_BITS-1:0] policy_way;

`ifdef TAG_CTRL_PLRU_EN
  // Each tree bit points toward the less recently used half.
  always_comb begin
    int node;
    policy_way = '0;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      policy_way[WAY_BITS-1-l] = plru_bits[node];
      node = 2 * node + 1 + int'(plru_bits[node]);
    end
  end
`else
  assign policy_way = rr_ptr;
`endif

  always_comb begin
    victim_way = policy_way;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim_way = WAY_BITS'(w);
    end
  end
endmodule

// File: rtl/tag_ctrl.sv
// rtl/tag_ctrl.sv - L1D tag lookup/allocate controller (IDLE/LOOKUP/UPDATE/RESP);
// define TAG_CTRL_PLRU_EN for per-set tree pseudo-LRU instead of a global round-robin pointer
module tag_ctrl
  import tag_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_wr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output logic [WAY_BITS-1:0]     rsp_way,
  output logic                    rsp_victim_valid,
  output logic                    rsp_victim_dirty,
  output logic [TAG_BITS-1:0]     rsp_victim_tag,
  output logic                    tm_en,
  output logic                    tm_wr,
  output logic [31:0]             tm_addr,
  output logic [32*NUM_WAY-1:0]   tm_wdata,
  input  logic [32*NUM_WAY-1:0]   tm_rdata
);
  state_e                state_q, state_d;
  logic [SET_BITS-1:0]   set_q, set_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  wr_q, wr_d;
  logic [32*NUM_WAY-1:0] row_q, row_d;
  logic                  hit_q, hit_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic                  vvalid_q, vvalid_d;
  logic                  vdirty_q, vdirty_d;
  logic [TAG_BITS-1:0]   vtag_q, vtag_d;

  logic [NUM_WAY-1:0]    valid_vec, hit_vec;
  logic [WAY_BITS-1:0]   hit_way, victim_way;
  logic [31:0]           victim_entry, new_entry;

  always_comb begin
    valid_vec = '0;
    hit_vec   = '0;
    hit_way   = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      valid_vec[w] = tm_rdata[32*w + VALID_BIT];
      hit_vec[w]   = valid_vec[w] && (tm_rdata[32*w +: TAG_BITS] == tag_q);
    end
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
    end
  end

  assign victim_entry = tm_rdata[32*victim_way +: 32];
  assign new_entry    = {1'b1, wr_q, {(30-TAG_BITS){1'b0}}, tag_q};

`ifdef TAG_CTRL_PLRU_EN
  logic [NUM_WAY-2:0]  plru_q [1<<SET_BITS];
  logic [NUM_WAY-2:0]  plru_row_d;
  logic [WAY_BITS-1:0] access_way;

  // Every lookup touches a way (hit or allocate); steer the path bits away from it.
  always_comb begin
    int node;
    access_way = (hit_vec != '0) ? hit_way : victim_way;
    plru_row_d = plru_q[set_q];
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      plru_row_d[node] = ~access_way[WAY_BITS-1-l];
      node = 2 * node + 1 + int'(access_way[WAY_BITS-1-l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < (1 << SET_BITS); s++) plru_q[s] <= '0;
    end else if (state_q == LOOKUP) begin
      plru_q[set_q] <= plru_row_d;
    end
  end

  tag_victim_sel u_victim_sel (
    .valid_vec  (valid_vec),
    .plru_bits  (plru_q[set_q]),
    .victim_way (victim_way)
  );
`else
  logic [WAY_BITS-1:0] ptr_q, ptr_d;

  assign ptr_d = (state_q == LOOKUP && hit_vec == '0 && victim_entry[VALID_BIT])
                 ? ptr_q + 1'b1 : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  tag_victim_sel u_victim_sel (
    .valid_vec  (valid_vec),
    .rr_ptr     (ptr_q),
    .victim_way (victim_way)
  );
`endif

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    tag_d    = tag_q;
    wr_d     = wr_q;
    row_d    = row_q;
    hit_d    = hit_q;
    way_d    = way_q;
    vvalid_d = vvalid_q;
    vdirty_d = vdirty_q;
    vtag_d   = vtag_q;
    tm_en    = 1'b0;
    tm_wr    = 1'b0;
    tm_addr  = '0;
    tm_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          set_d   = req_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
          tag_d   = req_addr[31:32-TAG_BITS];
          wr_d    = req_wr;
          tm_en   = 1'b1;
          tm_addr = {{(32-SET_BITS){1'b0}}, req_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS]};
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        row_d    = tm_rdata;
        hit_d    = (hit_vec != '0);
        vvalid_d = 1'b0;
        vdirty_d = 1'b0;
        vtag_d   = '0;
        if (hit_vec != '0) begin
          way_d = hit_way;
          if (wr_q && !tm_rdata[32*hit_way + DIRTY_BIT]) begin
            row_d[32*hit_way + DIRTY_BIT] = 1'b1;
            state_d = UPDATE;
          end else begin
            state_d = RESP;
          end
        end else begin
          way_d    = victim_way;
          vvalid_d = victim_entry[VALID_BIT];
          vdirty_d = victim_entry[DIRTY_BIT];
          vtag_d   = victim_entry[TAG_BITS-1:0];
          row_d[32*victim_way +: 32] = new_entry;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        tm_en    = 1'b1;
        tm_wr    = 1'b1;
        tm_addr  = {{(32-SET_BITS){1'b0}}, set_q};
        tm_wdata = row_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      wr_q     <= 1'b0;
      row_q    <= '0;
      hit_q    <= 1'b0;
      way_q    <= '0;
      vvalid_q <= 1'b0;
      vdirty_q <= 1'b0;
      vtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      tag_q    <= tag_d;
      wr_q     <= wr_d;
      row_q    <= row_d;
      hit_q    <= hit_d;
      way_q    <= way_d;
      vvalid_q <= vvalid_d;
      vdirty_q <= vdirty_d;
      vtag_q   <= vtag_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign rsp_valid        = (state_q == RESP);
  assign rsp_hit          = hit_q;
  assign rsp_way          = way_q;
  assign rsp_victim_valid = vvalid_q;
  assign rsp_victim_dirty = vdirty_q;
  assign rsp_victim_tag   = vtag_q;
endmodule

// File: tb/tb_tag_ctrl.sv
// tb/tb_tag_ctrl.sv - directed bench for tag_ctrl with a behavioural tag memory
module tb_tag_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_wr = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_hit;
  logic [2:0]   rsp_way;
  logic         rsp_victim_valid;
  logic         rsp_victim_dirty;
  logic [19:0]  rsp_victim_tag;
  logic         tm_en;
  logic         tm_wr;
  logic [31:0]  tm_addr;
  logic [255:0] tm_wdata;
  logic [255:0] tm_rdata = '0;

  logic [255:0] mem [128];
  int           wr_cnt = 0;
  logic [255:0] last_wdata = '0;
  logic [31:0]  last_waddr = '0;
  int           checks = 0;
  int           errors = 0;

  tag_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_wr           (req_wr),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_hit          (rsp_hit),
    .rsp_way          (rsp_way),
    .rsp_victim_valid (rsp_victim_valid),
    .rsp_victim_dirty (rsp_victim_dirty),
    .rsp_victim_tag   (rsp_victim_tag),
    .tm_en            (tm_en),
    .tm_wr            (tm_wr),
    .tm_addr          (tm_addr),
    .tm_wdata         (tm_wdata),
    .tm_rdata         (tm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tm_en && !tm_wr) tm_rdata <= mem[tm_addr[6:0]];
    if (tm_en && tm_wr) begin
      mem[tm_addr[6:0]] <= tm_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= tm_wdata;
      last_waddr <= tm_addr;
    end
  end

  task automatic do_req(input logic [31:0] a, input logic w, output int lat);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_before_req: got %b want 1", req_ready); end
    req_addr  = a;
    req_wr    = w;
    req_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 20);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout addr=%h: rsp_valid=%b want 1", a, rsp_valid); end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_after_rsp: got %b want 1", req_ready); end
  endtask

  task automatic test_reset();
    checks++; if ({req_ready, rsp_valid, tm_en, tm_wr} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl: got %b want 1000", {req_ready, rsp_valid, tm_en, tm_wr}); end
    checks++; if ({rsp_hit, rsp_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag} !== 26'd0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_hit, rsp_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag}); end
    checks++; if (tm_addr !== 32'd0 || tm_wdata !== 256'd0) begin errors++; $display("FAIL reset_tm: addr %h wdata %h want 0", tm_addr, tm_wdata); end
  endtask

  task automatic test_miss_alloc();
    int lat, w0;
    w0 = wr_cnt;
    do_req(32'h0000_1040, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL miss_latency: got %0d want 3", lat); end
    checks++; if (rsp_hit !== 1'b0 || rsp_way !== 3'd0 || rsp_victim_valid !== 1'b0) begin errors++; $display("FAIL miss_rsp: hit %b way %0d vv %b want 0 0 0", rsp_hit, rsp_way, rsp_victim_valid); end
    checks++; if (wr_cnt - w0 !== 1 || last_waddr !== 32'd2) begin errors++; $display("FAIL miss_write: writes %0d addr %h want 1 and 2", wr_cnt - w0, last_waddr); end
    checks++; if (last_wdata !== {224'd0, 32'h8000_0001}) begin errors++; $display("FAIL miss_wdata: got %h want 80000001", last_wdata); end
    finish_rsp();
  endtask

  task automatic test_load_hit();
    int lat, w0;
    w0 = wr_cnt;
    do_req(32'h0000_1040, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_hit_latency: got %0d want 2", lat); end
    checks++; if (rsp_hit !== 1'b1 || rsp_way !== 3'd0) begin errors++; $display("FAIL load_hit_rsp: hit %b way %0d want 1 0", rsp_hit, rsp_way); end
    checks++; if ({rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag} !== 22'd0) begin errors++; $display("FAIL load_hit_victim: got %h want 0", {rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag}); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL load_hit_nowrite: writes %0d want 0", wr_cnt - w0); end
    finish_rsp();
  endtask

  task automatic test_store_hit();
    int lat, w0;
    w0 = wr_cnt;
    do_req(32'h0000_1040, 1'b1, lat);
    checks++; if (lat !== 3 || rsp_hit !== 1'b1 || rsp_way !== 3'd0) begin errors++; $display("FAIL store_clean: lat %0d hit %b way %0d want 3 1 0", lat, rsp_hit, rsp_way); end
    checks++; if (wr_cnt - w0 !== 1 || last_wdata[31:0] !== 32'hC000_0001) begin errors++; $display("FAIL store_clean_write: writes %0d entry %h want 1 C0000001", wr_cnt - w0, last_wdata[31:0]); end
    finish_rsp();
    w0 = wr_cnt;
    do_req(32'h0000_1040, 1'b1, lat);
    checks++; if (lat !== 2 || rsp_hit !== 1'b1 || wr_cnt !== w0) begin errors++; $display("FAIL store_dirty: lat %0d hit %b writes %0d want 2 1 0", lat, rsp_hit, wr_cnt - w0); end
    finish_rsp();
  endtask

  task automatic test_fill_evict();
    int lat;
    for (int t = 2; t <= 8; t++) begin
      do_req((32'(t) << 12) | 32'h40, 1'b0, lat);
      checks++; if (rsp_hit !== 1'b0 || rsp_way !== 3'(t - 1) || rsp_victim_valid !== 1'b0) begin errors++; $display("FAIL fill_tag%0d: hit %b way %0d vv %b want 0 %0d 0", t, rsp_hit, rsp_way, rsp_victim_valid, t - 1); end
      finish_rsp();
    end
    do_req(32'h0000_9040, 1'b0, lat);
    checks++; if (rsp_hit !== 1'b0 || rsp_way !== 3'd0) begin errors++; $display("FAIL evict_way: hit %b way %0d want 0 0", rsp_hit, rsp_way); end
    checks++; if (rsp_victim_valid !== 1'b1 || rsp_victim_dirty !== 1'b1 || rsp_victim_tag !== 20'h00001) begin errors++; $display("FAIL evict_victim: v %b d %b tag %h want 1 1 00001", rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag); end
    checks++; if (last_wdata[31:0] !== 32'h8000_0009 || last_wdata[63:32] !== 32'h8000_0002) begin errors++; $display("FAIL evict_wdata: w0 %h w1 %h want 80000009 80000002", last_wdata[31:0], last_wdata[63:32]); end
    finish_rsp();
    do_req(32'h0000_A040, 1'b0, lat);
    checks++; if (rsp_way !== 3'd1 || rsp_victim_valid !== 1'b1 || rsp_victim_dirty !== 1'b0 || rsp_victim_tag !== 20'h00002) begin errors++; $display("FAIL evict_ptr1: way %0d v %b d %b tag %h want 1 1 0 00002", rsp_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag); end
    finish_rsp();
  endtask

  task automatic test_rsp_stall();
    int lat;
    do_req(32'h0000_9040, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_way !== 3'd0 || req_ready !== 1'b0 || tm_en !== 1'b0) begin errors++; $display("FAIL stall_cycle%0d: valid %b hit %b way %0d ready %b en %b want 1 1 0 0 0", i, rsp_valid, rsp_hit, rsp_way, req_ready, tm_en); end
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_req(32'h0000_A040, 1'b0, lat);
    checks++; if (lat !== 2 || rsp_hit !== 1'b1 || rsp_way !== 3'd1) begin errors++; $display("FAIL b2b_hit: lat %0d hit %b way %0d want 2 1 1", lat, rsp_hit, rsp_way); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int lat, w0;
    @(negedge clk);
    req_addr  = 32'h0000_B040;
    req_wr    = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (tm_en !== 1'b1 || tm_wr !== 1'b1) begin errors++; $display("FAIL mid_in_update: en %b wr %b want 1 1", tm_en, tm_wr); end
    w0 = wr_cnt;
    rst = 1'b1;
    #1;
    checks++; if (tm_en !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_async: en %b ready %b want 0 1", tm_en, req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (tm_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_quiet%0d: en %b valid %b ready %b want 0 0 1", i, tm_en, rsp_valid, req_ready); end
    end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL mid_nowrite: writes %0d want 0", wr_cnt - w0); end
    do_req(32'h0000_C040, 1'b0, lat);
    checks++; if (rsp_way !== 3'd0 || rsp_victim_valid !== 1'b1 || rsp_victim_dirty !== 1'b0 || rsp_victim_tag !== 20'h00009) begin errors++; $display("FAIL mid_ptr_reset: way %0d v %b d %b tag %h want 0 1 0 00009", rsp_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag); end
    finish_rsp();
  endtask

  initial begin
    for (int s = 0; s < 128; s++) mem[s] = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_miss_alloc();
    test_load_hit();
    test_store_hit();
    test_fill_evict();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
